// File: rtl/lpif_dstrm_flit_pairer_if.sv
`default_nettype none
// ============================================================================
//  Module      : lpif_dstrm_flit_pairer_if
//  Description : Flit input stream and paired dstrm_* beat bundle for the
//                LPIF downstream flit pairer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lpif_dstrm_flit_pairer_if #(
    parameter int FLIT_W = 512,
    parameter int CRC_W  = 16
);
    // Single-flit link-layer stream
    logic [7:0]          in_state;
    logic [3:0]          in_protid;
    logic [FLIT_W-1:0]   in_flit;
    logic [CRC_W-1:0]    in_crc;
    logic                in_crc_valid;
    logic                in_valid;
    logic                in_ready;

    // Two-lane beat towards the adapter
    logic [7:0]          dstrm_state;
    logic [3:0]          dstrm_protid;
    logic [2*FLIT_W-1:0] dstrm_data;
    logic [1:0]          dstrm_dvalid;
    logic [2*CRC_W-1:0]  dstrm_crc;
    logic [1:0]          dstrm_crc_valid;
    logic [1:0]          dstrm_valid;

    // Link-layer source side
    modport master (
        output in_state, in_protid, in_flit, in_crc, in_crc_valid, in_valid,
        input  in_ready,
        input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
        input  dstrm_crc, dstrm_crc_valid, dstrm_valid
    );

    // Pairer side
    modport slave (
        input  in_state, in_protid, in_flit, in_crc, in_crc_valid, in_valid,
        output in_ready,
        output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
        output dstrm_crc, dstrm_crc_valid, dstrm_valid
    );
endinterface
`default_nettype wire

// File: rtl/lpif_dstrm_flit_pairer.sv
`default_nettype none
// ============================================================================
//  Module      : lpif_dstrm_flit_pairer
//  Description : Packs consecutive single flits into two-lane dstrm_* beats.
//                A lone flit is flushed as a half beat on protocol-ID change,
//                link offline, or after flush_delay idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module lpif_dstrm_flit_pairer #(
    parameter int FLIT_W = 512,
    parameter int CRC_W  = 16,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk_wr,
    input  wire logic             rst_wr_n,
    input  wire logic             tx_online,
    input  wire logic [7:0]       flush_delay,
    lpif_dstrm_flit_pairer_if.slave bus,
    output logic      [CNT_W-1:0] pair_cnt,
    output logic      [CNT_W-1:0] single_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HALF = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          idle_q, idle_d;

    logic [FLIT_W-1:0]   held_flit_q;
    logic [CRC_W-1:0]    held_crc_q;
    logic                held_crcv_q;
    logic [3:0]          held_pid_q;

    logic [7:0]          state_out_q;
    logic [3:0]          pid_out_q;
    logic [2*FLIT_W-1:0] data_out_q;
    logic [1:0]          dvalid_out_q;
    logic [2*CRC_W-1:0]  crc_out_q;
    logic [1:0]          crcv_out_q;
    logic [CNT_W-1:0]    pair_cnt_q;
    logic [CNT_W-1:0]    single_cnt_q;

    logic                accept;
    logic                load;
    logic                emit_pair;
    logic                emit_single;

    // The adapter never stalls, so acceptance depends only on link state.
    assign bus.in_ready = tx_online;
    assign accept       = bus.in_valid & tx_online;

    // State register and idle counter
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q <= ST_IDLE;
            idle_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
        end
    end

    // Next-state decode; priority: protid change > pair > offline > timeout
    always_comb begin
        state_d     = state_q;
        idle_d      = idle_q;
        load        = 1'b0;
        emit_pair   = 1'b0;
        emit_single = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    idle_d  = 8'd0;
                    state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                if (accept && (bus.in_protid != held_pid_q)) begin
                    emit_single = 1'b1;
                    load        = 1'b1;
                    idle_d      = 8'd0;
                end else if (accept) begin
                    emit_pair = 1'b1;
                    idle_d    = 8'd0;
                    state_d   = ST_IDLE;
                end else if (!tx_online) begin
                    emit_single = 1'b1;
                    idle_d      = 8'd0;
                    state_d     = ST_IDLE;
                end else if (idle_q == flush_delay) begin
                    emit_single = 1'b1;
                    idle_d      = 8'd0;
                    state_d     = ST_IDLE;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idle_d  = 8'd0;
            end
        endcase
    end

    // Lane0 holding register for the unpaired flit
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            held_flit_q <= '0;
            held_crc_q  <= '0;
            held_crcv_q <= 1'b0;
            held_pid_q  <= 4'd0;
        end else if (load) begin
            held_flit_q <= bus.in_flit;
            held_crc_q  <= bus.in_crc;
            held_crcv_q <= bus.in_crc_valid;
            held_pid_q  <= bus.in_protid;
        end
    end

    // Beat output registers; lane1 payload holds across half beats
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_out_q  <= 8'd0;
            pid_out_q    <= 4'd0;
            data_out_q   <= '0;
            dvalid_out_q <= 2'b00;
            crc_out_q    <= '0;
            crcv_out_q   <= 2'b00;
        end else begin
            state_out_q  <= bus.in_state;
            dvalid_out_q <= 2'b00;
            crcv_out_q   <= 2'b00;
            if (emit_pair) begin
                pid_out_q    <= held_pid_q;
                data_out_q   <= {bus.in_flit, held_flit_q};
                crc_out_q    <= {bus.in_crc, held_crc_q};
                crcv_out_q   <= {bus.in_crc_valid, held_crcv_q};
                dvalid_out_q <= 2'b11;
            end else if (emit_single) begin
                pid_out_q              <= held_pid_q;
                data_out_q[FLIT_W-1:0] <= held_flit_q;
                crc_out_q[CRC_W-1:0]   <= held_crc_q;
                crcv_out_q             <= {1'b0, held_crcv_q};
                dvalid_out_q           <= 2'b01;
            end
        end
    end

    // Saturating full/half beat counters
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            pair_cnt_q   <= '0;
            single_cnt_q <= '0;
        end else begin
            if (emit_pair && (pair_cnt_q != {CNT_W{1'b1}})) begin
                pair_cnt_q <= pair_cnt_q + 1'b1;
            end
            if (emit_single && (single_cnt_q != {CNT_W{1'b1}})) begin
                single_cnt_q <= single_cnt_q + 1'b1;
            end
        end
    end

    assign bus.dstrm_state     = state_out_q;
    assign bus.dstrm_protid    = pid_out_q;
    assign bus.dstrm_data      = data_out_q;
    assign bus.dstrm_dvalid    = dvalid_out_q;
    assign bus.dstrm_valid     = dvalid_out_q;
    assign bus.dstrm_crc       = crc_out_q;
    assign bus.dstrm_crc_valid = crcv_out_q;
    assign pair_cnt            = pair_cnt_q;
    assign single_cnt          = single_cnt_q;

endmodule
`default_nettype wire

// File: doc/lpif_dstrm_flit_pairer.md
# lpif_dstrm_flit_pairer

Upstream feeder for the x16 asym1 half-rate master LPIF adapter. Accepts a single-flit-per-cycle link-layer stream (512-bit flit plus CRC, protocol ID and state sideband) and packs consecutive flits into the two-lane, 1024-bit dstrm_* beat that the adapter consumes. A lone flit is flushed as a half beat when the pair partner does not arrive in time, when the protocol ID changes, or when the link goes offline. All outputs are registered.

## Interface
- FLIT_W, 512, width of one flit lane; dstrm_data is 2*FLIT_W
- CRC_W, 16, CRC width per lane; dstrm_crc is 2*CRC_W
- clk_wr  input  1  sole clock
- rst_wr_n  input  1  asynchronous active-low reset
- tx_online  input  1  link online; gates acceptance
- flush_delay  input  8  idle cycles tolerated while holding a lone flit
- in_state  input  8  link state sideband
- in_protid  input  4  protocol ID of in_flit
- in_flit  input  FLIT_W  flit payload
- in_crc  input  CRC_W  flit CRC
- in_crc_valid  input  1  in_crc qualifier
- in_valid  input  1  flit present
- in_ready  output  1  flit accepted when in_valid && in_ready
- dstrm_state  output  8  registered in_state
- dstrm_protid  output  4  protid of the emitted beat
- dstrm_data  output  2*FLIT_W  lane0 [FLIT_W-1:0], lane1 upper
- dstrm_dvalid  output  2  per-lane data valid
- dstrm_crc  output  2*CRC_W  lane0 low, lane1 high
- dstrm_crc_valid  output  2  per-lane CRC valid
- dstrm_valid  output  2  per-lane valid; equals dstrm_dvalid
- pair_cnt  output  16  saturating count of full beats emitted
- single_cnt  output  16  saturating count of half beats emitted

## Operation
- in_ready = tx_online, combinational. The adapter never stalls, so in_ready never depends on internal state.
- FSM states:
  - IDLE: nothing held.
  - HALF: lane0 holding register loaded, with idle_cnt (8 bits).
- IDLE + accept: load flit, crc, crc_valid and protid into lane0. Go to HALF with idle_cnt=0. No emission.
- HALF + accept, same protid: emit a pair. lane0 = held flit, lane1 = new flit, dvalid=2'b11. Go to IDLE.
- HALF + accept, different protid: emit the held flit as a single (dvalid=2'b01). Load the new flit into lane0. Stay in HALF with idle_cnt=0.
- HALF, no accept, tx_online=1:
  - If idle_cnt==flush_delay: emit single, go to IDLE.
  - Otherwise increment idle_cnt.
- HALF + tx_online=0: emit single, go to IDLE.
- Priority within HALF: protid mismatch > pair > offline flush > timeout flush. An accept always outranks a timeout in the same cycle.
- Emitted lane1 CRC valid = in_crc_valid. For singles: lane1 dvalid=0 and crc_valid=0, and lane1 data/crc hold their previous values.
- Non-emit cycles: dstrm_dvalid, dstrm_valid and dstrm_crc_valid = 0. data, crc and protid hold their last values.
- dstrm_state <= in_state every cycle, independent of the FSM.
- pair_cnt / single_cnt increment on each emitted full / half beat and saturate at 16'hFFFF.

## Timing
- Reset:
  - FSM=IDLE, idle_cnt=0.
  - All dstrm_* outputs = 0.
  - pair_cnt = single_cnt = 0.
  - in_ready follows tx_online.
- Reset asserted mid-HALF discards the held flit without emitting it.
- Pair latency: the second flit accepted in cycle N appears on dstrm_* in cycle N+1.
- Timeout latency: a lone flit accepted at N with no further input appears at N+2+flush_delay.
  - flush_delay=0 gives N+2.
- Offline flush: tx_online low at cycle M while in HALF → single appears at M+1.
- Back-to-back accepts produce one full beat every second cycle. Sustained throughput is 1 flit/cycle with no bubbles on input.
- Emission valid pulses last exactly one cycle.

## Test plan
- Reset, then 4 consecutive flits A,B,C,D with protid=1 → beats {B,A} at cycle 2 and {D,C} at cycle 4, dvalid=11. pair_cnt=2, single_cnt=0.
- One flit A, flush_delay=3, no further input → single at N+5 with dvalid=01 and lane1 crc_valid=0. single_cnt=1.
- A(protid=1) then B(protid=2) consecutively → A emitted as single at N+2. B held and pairs with C(protid=2) when C arrives.
- Hold A, drop tx_online two cycles later → A single one cycle after the drop. in_ready=0 while offline, and no beats are emitted while offline.
- Hold A, assert rst_wr_n=0 mid-HALF → all outputs 0 immediately. After release, A is never emitted.
- Force 65536 pairs → pair_cnt stops at 16'hFFFF.
